pos_link_rx: RTL

//  Receives the peer board's 10-bit parallel position word (PMOD JA/JB pins) and

---
 rtl/pos_link_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 31 +++
 rtl/pos_link_rx.sv | 138 +++++++++++++
 3 files changed

// File: rtl/pos_link_pkg.sv
// Shared definitions for the board-to-board position link (rx and tx sides).
// The link word is {odd parity bit, 9-bit position}.
package pos_link_pkg;

  localparam int POS_W  = 9;
  localparam int LINK_W = 10;

  typedef logic [POS_W-1:0] pos_t;

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    CHECK  = 2'd1,
    HOLD   = 2'd2
  } rx_state_t;

  // Parity bit that makes the full link word contain an odd number of ones.
  function automatic logic odd_parity(input pos_t pos);
    return ~(^pos);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser bank for asynchronous input pins.
module sync_2ff #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1_d, s1_q;
  logic [W-1:0] s2_d, s2_q;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/pos_link_rx.sv
// Receives the peer's parallel position word, filters out skewed/transitional
// samples, checks odd parity and tracks link presence with a timeout.
module pos_link_rx
  import pos_link_pkg::*;
#(
  parameter int STABLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 6_500_000,
  parameter int ERR_W          = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LINK_W-1:0] pos_raw,
  output pos_t              pos_out,
  output logic              pos_valid,
  output logic              link_ok,
  output logic              parity_err,
  output logic [ERR_W-1:0]  err_count
);

  localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
  localparam int TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(STABLE_CYCLES);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  logic [LINK_W-1:0] s2;

  sync_2ff #(.W(LINK_W)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pos_raw),
    .q     (s2)
  );

  logic [LINK_W-1:0] prev_d, prev_q;
  logic [STAB_W-1:0] stab_cnt_d, stab_cnt_q;
  logic [TO_W-1:0]   to_cnt_d, to_cnt_q;
  rx_state_t         state_d, state_q;
  pos_t              pos_d, pos_q;
  logic              pos_valid_d, pos_valid_q;
  logic              link_ok_d, link_ok_q;
  logic              parity_err_d, parity_err_q;
  logic [ERR_W-1:0]  err_count_d, err_count_q;

  logic changed, stable, parity_ok, accept, reject, to_expire;

  always_comb begin
    changed   = (s2 != prev_q);
    stable    = (stab_cnt_q == STAB_LAST) && !changed;
    // In CHECK, prev_q still holds the word that produced the stable event,
    // even if the pins moved again this cycle.
    parity_ok = (prev_q[LINK_W-1] == odd_parity(prev_q[POS_W-1:0]));
    accept    = (state_q == CHECK) && parity_ok;
    reject    = (state_q == CHECK) && !parity_ok;
    to_expire = (to_cnt_q == TO_LAST);

    prev_d       = s2;
    stab_cnt_d   = stab_cnt_q;
    to_cnt_d     = to_cnt_q;
    state_d      = state_q;
    pos_d        = pos_q;
    pos_valid_d  = 1'b0;
    link_ok_d    = link_ok_q;
    parity_err_d = 1'b0;
    err_count_d  = err_count_q;

    if (changed) begin
      stab_cnt_d = '0;
    end else if (stab_cnt_q != STAB_MAX) begin
      stab_cnt_d = stab_cnt_q + STAB_W'(1);
    end

    case (state_q)
      SETTLE:  if (stable) state_d = CHECK;
      CHECK:   state_d = (parity_ok && !changed) ? HOLD : SETTLE;
      HOLD:    if (changed) state_d = SETTLE;
      default: state_d = SETTLE;
    endcase

    // A repeated value is re-announced only when the link had been lost.
    if (accept) begin
      link_ok_d = 1'b1;
      if ((prev_q[POS_W-1:0] != pos_q) || !link_ok_q) begin
        pos_d       = prev_q[POS_W-1:0];
        pos_valid_d = 1'b1;
      end
    end else if (to_expire) begin
      link_ok_d = 1'b0;
    end

    if (accept || (state_q == HOLD)) begin
      to_cnt_d = '0;
    end else if (!to_expire) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end

    if (reject) begin
      parity_err_d = 1'b1;
      err_count_d  = sat_inc(err_count_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q       <= '0;
      stab_cnt_q   <= '0;
      to_cnt_q     <= '0;
      state_q      <= SETTLE;
      pos_q        <= '0;
      pos_valid_q  <= 1'b0;
      link_ok_q    <= 1'b0;
      parity_err_q <= 1'b0;
      err_count_q  <= '0;
    end else begin
      prev_q       <= prev_d;
      stab_cnt_q   <= stab_cnt_d;
      to_cnt_q     <= to_cnt_d;
      state_q      <= state_d;
      pos_q        <= pos_d;
      pos_valid_q  <= pos_valid_d;
      link_ok_q    <= link_ok_d;
      parity_err_q <= parity_err_d;
      err_count_q  <= err_count_d;
    end
  end

  assign pos_out    = pos_q;
  assign pos_valid  = pos_valid_q;
  assign link_ok    = link_ok_q;
  assign parity_err = parity_err_q;
  assign err_count  = err_count_q;

endmodule
